// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing an 8-digit seven-segment display among four requesters,
// with a minimum hold time counted in slow display ticks.
module seg_display_arbiter #(
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_src,
    input  logic [3:0]   req,
    input  logic [127:0] data,
    output logic [3:0]   gnt,
    output logic [1:0]   owner,
    output logic         busy,
    output logic [3:0]   dig7,
    output logic [3:0]   dig6,
    output logic [3:0]   dig5,
    output logic [3:0]   dig4,
    output logic [3:0]   dig3,
    output logic [3:0]   dig2,
    output logic [3:0]   dig1,
    output logic [3:0]   dig0
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StSwitch
    } state_e;

    localparam logic [CNT_W-1:0] HoldInit = CNT_W'(HOLD_TICKS);

    state_e           state_q, state_d;
    logic             tick_src_q;
    logic             tick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      dig_q, dig_d;

    logic             rr_found;
    logic [1:0]       rr_idx;
    logic [1:0]       cand;
    logic [31:0]      owner_word;
    logic             others_req;

    assign tick       = tick_src & ~tick_src_q;
    assign owner_word = data[{owner_q, 5'b00000} +: 32];
    assign others_req = |(req & ~gnt_q);

    // Search starts just after the pointer, so the previous owner is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        dig_d    = dig_q;

        case (state_q)
            StIdle, StSwitch: begin
                if (rr_found) begin
                    state_d  = StGrant;
                    gnt_d    = 4'b0001 << rr_idx;
                    owner_d  = rr_idx;
                    rr_ptr_d = rr_idx;
                    busy_d   = 1'b1;
                    cnt_d    = HoldInit;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            StGrant: begin
                dig_d = owner_word;
                if (tick && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // An owner drop wins over expiry; both lead to the same break cycle.
                if (!req[owner_q] || ((cnt_q == '0) && others_req)) begin
                    state_d = StSwitch;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            tick_src_q <= 1'b0;
            cnt_q      <= '0;
            rr_ptr_q   <= 2'd3;
            owner_q    <= 2'd0;
            gnt_q      <= 4'b0000;
            busy_q     <= 1'b0;
            dig_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            tick_src_q <= tick_src;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            dig_q      <= dig_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign dig7  = dig_q[31:28];
    assign dig6  = dig_q[27:24];
    assign dig5  = dig_q[23:20];
    assign dig4  = dig_q[19:16];
    assign dig3  = dig_q[15:12];
    assign dig2  = dig_q[11:8];
    assign dig1  = dig_q[7:4];
    assign dig0  = dig_q[3:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: expected grant/busy/owner per cycle are queued
// with the stimulus and popped after each clock edge.
module tb_seg_display_arbiter;

    logic         clk;
    logic         rst;
    logic         tick_src;
    logic [3:0]   req;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic [1:0]   owner;
    logic         busy;
    logic [3:0]   dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   passed;

    seg_display_arbiter #(
        .HOLD_TICKS(4),
        .CNT_W     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_src(tick_src),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .dig7    (dig7),
        .dig6    (dig6),
        .dig5    (dig5),
        .dig4    (dig4),
        .dig3    (dig3),
        .dig2    (dig2),
        .dig1    (dig1),
        .dig0    (dig0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] digs();
        return {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive tick_src, queue the expected post-edge outputs, compare after the edge.
    task automatic cyc(input string tag, input logic ts, input logic [3:0] eg, input logic eb,
                       input logic [1:0] eo);
        exp_t e;
        tick_src = ts;
        sb_q.push_back({eg, eb, eo});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".owner"}, 32'(owner), 32'(e.owner));
    endtask

    // Four tick pulses of hold, one break cycle, then the next grant.
    task automatic hold_switch(input string tag, input logic [3:0] og, input logic [1:0] oo,
                               input logic [3:0] ng, input logic [1:0] no);
        for (int k = 0; k < 4; k++) begin
            cyc(tag, 1'b1, og, 1'b1, oo);
            if (k == 3) cyc(tag, 1'b0, 4'b0000, 1'b0, oo);
            else        cyc(tag, 1'b0, og, 1'b1, oo);
        end
        cyc(tag, 1'b0, ng, 1'b1, no);
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        rst      = 1'b0;
        tick_src = 1'b0;
        req      = 4'b0000;
        data              = '0;
        data[31:0]        = 32'h7654_3210;
        data[63:32]       = 32'h89AB_CDEF;
        data[95:64]       = 32'hABCD_1234;
        data[127:96]      = 32'h0F1E_2D3C;

        #12;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.owner", 32'(owner), 32'h0);
        chk("rst.dig", digs(), 32'h0);

        // First grant after reset release.
        rst = 1'b1;
        req = 4'b0001;
        cyc("t1", 1'b0, 4'b0001, 1'b1, 2'd0);
        cyc("t1", 1'b0, 4'b0001, 1'b1, 2'd0);
        chk("t1.dig", digs(), 32'h7654_3210);

        // Hold for four ticks against a waiting requester.
        req = 4'b0011;
        hold_switch("t2", 4'b0001, 2'd0, 4'b0010, 2'd1);
        cyc("t2", 1'b0, 4'b0010, 1'b1, 2'd1);
        chk("t2.dig", digs(), 32'h89AB_CDEF);
        data[31:0] = 32'h1111_1111;
        cyc("t2", 1'b0, 4'b0010, 1'b1, 2'd1);
        chk("t2.nonowner", digs(), 32'h89AB_CDEF);

        // Full rotation with everyone requesting.
        req = 4'b1111;
        hold_switch("t3a", 4'b0010, 2'd1, 4'b0100, 2'd2);
        hold_switch("t3b", 4'b0100, 2'd2, 4'b1000, 2'd3);
        hold_switch("t3c", 4'b1000, 2'd3, 4'b0001, 2'd0);
        hold_switch("t3d", 4'b0001, 2'd0, 4'b0010, 2'd1);

        // Owner 2 drops early; grant wraps past 3 and 0 to requester 1.
        hold_switch("t4a", 4'b0010, 2'd1, 4'b0100, 2'd2);
        req = 4'b0110;
        cyc("t4", 1'b1, 4'b0100, 1'b1, 2'd2);
        cyc("t4", 1'b0, 4'b0100, 1'b1, 2'd2);
        req = 4'b0010;
        cyc("t4", 1'b0, 4'b0000, 1'b0, 2'd2);
        cyc("t4", 1'b0, 4'b0010, 1'b1, 2'd1);

        // Idle holds digits; tick at grant entry and a glitch between edges are ignored.
        req = 4'b0000;
        cyc("t5", 1'b0, 4'b0000, 1'b0, 2'd1);
        cyc("t5", 1'b0, 4'b0000, 1'b0, 2'd1);
        chk("t5.idle_dig", digs(), 32'h89AB_CDEF);
        req = 4'b0001;
        cyc("t5", 1'b1, 4'b0001, 1'b1, 2'd0);
        req = 4'b0011;
        cyc("t5", 1'b0, 4'b0001, 1'b1, 2'd0);
        tick_src = 1'b1;
        #2;
        tick_src = 1'b0;
        cyc("t5", 1'b0, 4'b0001, 1'b1, 2'd0);
        hold_switch("t5h", 4'b0001, 2'd0, 4'b0010, 2'd1);

        // Asynchronous reset mid-grant, then priority restarts from requester 0.
        req = 4'b0100;
        cyc("t6", 1'b0, 4'b0000, 1'b0, 2'd1);
        cyc("t6", 1'b0, 4'b0100, 1'b1, 2'd2);
        cyc("t6", 1'b0, 4'b0100, 1'b1, 2'd2);
        chk("t6.dig", digs(), 32'hABCD_1234);
        rst = 1'b0;
        #1;
        chk("t6.rst_gnt", 32'(gnt), 32'h0);
        chk("t6.rst_busy", 32'(busy), 32'h0);
        chk("t6.rst_owner", 32'(owner), 32'h0);
        chk("t6.rst_dig", digs(), 32'h0);
        req = 4'b1100;
        #3;
        rst = 1'b1;
        cyc("t6r", 1'b0, 4'b0100, 1'b1, 2'd2);
        cyc("t6r", 1'b0, 4'b0100, 1'b1, 2'd2);
        chk("t6r.dig", digs(), 32'hABCD_1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the 8-digit seven-segment display interface among four independent requesters (e.g. counter, clock, status, debug).
- Each requester presents a 32-bit word of eight hex nibbles.
- Round-robin arbitration; an owner is guaranteed a minimum display time, counted in slow display ticks.
- Drives dig7..dig0 of the segment interface directly; consumes its div_clk output as the tick source.

Parameters:
- HOLD_TICKS, 4, minimum number of tick_src rising edges an owner keeps the display once another requester is waiting (0 = preemptible immediately).
- CNT_W, 4, width of the hold counter; must hold HOLD_TICKS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick_src  input  1  slow level clock (div_clk of segment interface); sampled in clk domain
- req  input  4  request per requester, level, held while display wanted
- data  input  128  packed words; requester i word = data[32i+31:32i]; nibble k of word -> digk
- gnt  output  4  one-hot grant, registered
- owner  output  2  index of current/last owner
- busy  output  1  high while any grant active
- dig7..dig0  output  4 each  digit values to segment interface

Behaviour:
- Reset (rst=0, async): gnt=0, owner=0, busy=0, all dig=0, hold counter=0, tick edge register=0, FSM=IDLE, rr pointer = 3 (requester 0 highest priority first).
- Tick: tick_src registered once; tick = tick_src & ~tick_src_q, single-cycle pulse.
- Round-robin search order starts at rr_pointer+1 mod 4 and wraps.
- FSM states:
  - IDLE: gnt=0, busy=0, dig hold last value.
    - Any req -> GRANT to first requester in round-robin order.
    - Grant visible the cycle after req is sampled (1-cycle latency).
  - GRANT:
    - gnt one-hot, busy=1, owner = index, rr_pointer = owner.
    - Counter loads HOLD_TICKS on entry.
    - Each dig registered from owner's nibble every cycle (1-cycle latency; live mirror).
    - Counter decrements on tick, saturates at 0.
    - Owner deasserts req -> SWITCH next cycle (regardless of counter).
    - Counter==0 and any other req pending -> SWITCH.
    - Counter==0 and no other req -> stay.
  - SWITCH: one cycle, gnt=0, busy=0, dig hold last value (break-before-make).
    - Next: GRANT to first requester in round-robin order after old owner, if any req is asserted.
    - Otherwise -> IDLE.
    - Old owner may be regranted only if it is the sole requester.
- Simultaneous events:
  - Owner drop with counter expiry: treated as drop.
  - Tick in cycle of counter load: load wins, tick ignored.
  - Reqs changing during SWITCH: sampled in SWITCH cycle only.
- Only the granted requester's data affects outputs; non-owner data changes are ignored.
- Reset asserted mid-grant: immediate return to reset values; after release, arbitration restarts with requester 0 first.
- owner retains last value in IDLE/SWITCH; busy distinguishes.

Test Plan:
- Reset release, req=0001, data[31:0]=0x76543210 -> gnt=0001 one cycle later, dig7..dig0 = 7,6,5,4,3,2,1,0 next cycle, busy=1.
- Owner 0 holding, req becomes 0011, HOLD_TICKS=4 -> gnt stays 0001 for exactly 4 tick edges, then one cycle gnt=0000, then gnt=0010, owner=1.
- All four req held continuously -> grants rotate 0->1->2->3->0, each with 4-tick hold and a 1-cycle gap.
- Owner 2 drops req at counter=3 with req 1 pending -> SWITCH next cycle, then gnt=0010 (wrap past 3,0 to 1); no wait for hold.
- Tick edge coincident with grant entry -> counter equals HOLD_TICKS after entry; a single-cycle pulse on tick_src that spans no rising clk edge produces no decrement.
- rst pulsed low while gnt=0100 and dig show 0xABCD1234 -> gnt=0, busy=0, all dig=0 asynchronously; after release with req=1100, gnt=0100 (requester 2 wins by priority from 0).
